// File: rtl/control_unit.sv
// control_unit: multi-cycle controller for the 16-bit core.
// Holds the program counter and instruction register. Fetches from unified memory and
// steps each instruction through FETCH, DECODE, EXEC, MEM/WB (or HALT).
//
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   mem_rdata             memory read data for the current mem_addr
//   alu_out, alu_eq       ALU result and register equality flag
//   reg_out1              register file rB read port (JALR target)
//   instruction, pc       instruction register and current pc, to the register file
//   mem_addr, mem_we      memory address and write strobe
//   MUX_tgt, MUX_rf       register file write-data select and second read port select
//   WE_rf                 register file write enable
//   alu_op, alu_src_imm   ALU operation and immediate operand-B select
//   halted                core halted
module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_rdata,
  input  logic [15:0] alu_out,
  input  logic        alu_eq,
  input  logic [15:0] reg_out1,
  output logic [15:0] instruction,
  output logic [15:0] pc,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [1:0]  MUX_tgt,
  output logic        MUX_rf,
  output logic        WE_rf,
  output logic [1:0]  alu_op,
  output logic        alu_src_imm,
  output logic        halted
);

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StMem    = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;
  localparam logic [2:0] StHalt   = 3'd5;

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpAddi = 3'b001;
  localparam logic [2:0] OpNand = 3'b010;
  localparam logic [2:0] OpLui  = 3'b011;
  localparam logic [2:0] OpSw   = 3'b100;
  localparam logic [2:0] OpLw   = 3'b101;
  localparam logic [2:0] OpBeq  = 3'b110;
  localparam logic [2:0] OpJalr = 3'b111;

  logic [2:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;

  logic [2:0]  w_state_next;
  logic [15:0] w_pc_next;
  logic [15:0] w_ir_next;
  logic [2:0]  w_opcode;
  logic        w_is_halt;
  logic [15:0] w_pc_inc;
  logic [15:0] w_br_off;

  assign w_opcode  = r_ir[15:13];
  // HALT shares the JALR opcode; a nonzero immediate field distinguishes it.
  assign w_is_halt = (w_opcode == OpJalr) && (r_ir[6:0] != 7'd0);
  assign w_pc_inc  = r_pc + 16'd1;
  assign w_br_off  = {{9{r_ir[6]}}, r_ir[6:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StFetch;
      r_pc    <= 16'h0000;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
    end
  end

  // Next state, pc and IR. pc moves only on the last cycle of an instruction.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    case (r_state)
      StFetch: begin
        w_ir_next    = mem_rdata;
        w_state_next = StDecode;
      end
      StDecode: begin
        w_state_next = w_is_halt ? StHalt : StExec;
      end
      StExec: begin
        case (w_opcode)
          OpLw, OpSw: w_state_next = StMem;
          OpBeq: begin
            w_pc_next    = alu_eq ? (w_pc_inc + w_br_off) : w_pc_inc;
            w_state_next = StFetch;
          end
          OpJalr: begin
            w_pc_next    = reg_out1;
            w_state_next = StFetch;
          end
          default: w_state_next = StWb;
        endcase
      end
      StMem, StWb: begin
        w_pc_next    = w_pc_inc;
        w_state_next = StFetch;
      end
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StFetch;
    endcase
  end

  // Moore outputs decoded from state and IR.
  always_comb begin
    mem_addr    = r_pc;
    mem_we      = 1'b0;
    MUX_tgt     = 2'b00;
    MUX_rf      = 1'b0;
    WE_rf       = 1'b0;
    alu_op      = 2'b00;
    alu_src_imm = 1'b0;
    halted      = 1'b0;

    // ALU controls are set in EXEC and held through MEM/WB so alu_out stays stable.
    if (r_state == StExec || r_state == StMem || r_state == StWb) begin
      case (w_opcode)
        OpNand:            alu_op = 2'b01;
        OpLui:             alu_op = 2'b10;
        OpAddi, OpLw, OpSw: alu_src_imm = 1'b1;
        default:           alu_op = 2'b00;
      endcase
    end

    case (r_state)
      StExec: begin
        if (w_opcode == OpBeq) MUX_rf = 1'b1;
        if (w_opcode == OpJalr) begin
          WE_rf   = 1'b1;
          MUX_tgt = 2'b10;
        end
      end
      StMem: begin
        mem_addr = alu_out;
        if (w_opcode == OpLw) WE_rf = 1'b1;
        if (w_opcode == OpSw) begin
          MUX_rf = 1'b1;
          mem_we = 1'b1;
        end
      end
      StWb: begin
        WE_rf   = 1'b1;
        MUX_tgt = 2'b01;
      end
      StHalt:  halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

  assign instruction = r_ir;
  assign pc          = r_pc;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit. Memory is modelled as a flat array; ALU and
// register file inputs are driven directly. Per-cycle expected output vectors are queued
// as each instruction is issued and compared at the falling edge.
module tb_control_unit;

  typedef logic [56:0] vec_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] mem_rdata;
  logic [15:0] alu_out;
  logic        alu_eq;
  logic [15:0] reg_out1;
  logic [15:0] instruction;
  logic [15:0] pc;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [1:0]  MUX_tgt;
  logic        MUX_rf;
  logic        WE_rf;
  logic [1:0]  alu_op;
  logic        alu_src_imm;
  logic        halted;

  bit [15:0] mem [0:65535];
  vec_t      sb[$];
  int        errors;
  int        checks;
  logic [15:0] m_pc;
  logic [15:0] m_ir;

  control_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_rdata   (mem_rdata),
    .alu_out     (alu_out),
    .alu_eq      (alu_eq),
    .reg_out1    (reg_out1),
    .instruction (instruction),
    .pc          (pc),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .MUX_tgt     (MUX_tgt),
    .MUX_rf      (MUX_rf),
    .WE_rf       (WE_rf),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .halted      (halted)
  );

  assign mem_rdata = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Field order: WE_rf mem_we MUX_tgt MUX_rf alu_op alu_src_imm halted pc mem_addr IR
  function automatic vec_t mk(input logic we, input logic mwe, input logic [1:0] tgt,
                              input logic rf, input logic [1:0] op, input logic imm,
                              input logic h, input logic [15:0] p, input logic [15:0] a,
                              input logic [15:0] ir);
    return {we, mwe, tgt, rf, op, imm, h, p, a, ir};
  endfunction

  function automatic vec_t obs();
    return {WE_rf, mem_we, MUX_tgt, MUX_rf, alu_op, alu_src_imm, halted, pc, mem_addr,
            instruction};
  endfunction

  task automatic test_reset();
    vec_t got;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    got = obs();
    checks++;
    if (got !== mk(0, 0, 2'b00, 0, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0)) begin
      errors++;
      $display("FAIL reset got=%h exp=%h", got, mk(0, 0, 2'b00, 0, 2'b00, 0, 0, 16'h0,
               16'h0, 16'h0));
    end
    rst_n = 1'b1;
    m_pc = 16'h0000;
    m_ir = 16'h0000;
  endtask

  task automatic test_reset_mid();
    vec_t got;
    vec_t exp;
    mem[16'h0000] = 16'h0503;
    sb.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 0, 16'h0, 16'h0, m_ir));
    sb.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0503));
    sb.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0503));
    for (int i = 0; sb.size() > 0; i++) begin
      exp = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_mid cyc%0d got=%h exp=%h", i, got, exp);
      end
      if (i == 2) rst_n = 1'b0;
      @(negedge clk);
    end
    got = obs();
    checks++;
    if (got !== mk(0, 0, 2'b00, 0, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0)) begin
      errors++;
      $display("FAIL reset_mid_after got=%h exp=%h", got, mk(0, 0, 2'b00, 0, 2'b00, 0, 0,
               16'h0, 16'h0, 16'h0));
    end
    rst_n = 1'b1;
    m_pc = 16'h0000;
    m_ir = 16'h0000;
  endtask

  // ADD/ADDI/NAND/LUI: F, D, E, WB.
  task automatic test_wb(input string name, input logic [15:0] word, input logic [1:0] op,
                         input logic imm);
    vec_t got;
    vec_t exp;
    mem[m_pc] = word;
    alu_out = 16'($urandom);
    sb.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 0, m_pc, m_pc, m_ir));
    sb.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 0, m_pc, m_pc, word));
    sb.push_back(mk(0, 0, 2'b00, 0, op, imm, 0, m_pc, m_pc, word));
    sb.push_back(mk(1, 0, 2'b01, 0, op, imm, 0, m_pc, m_pc, word));
    m_ir = word;
    m_pc = m_pc + 16'd1;
    for (int i = 0; sb.size() > 0; i++) begin
      exp = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s cyc%0d got=%h exp=%h", name, i, got, exp);
      end
      @(negedge clk);
    end
  endtask

  // LW/SW: F, D, E, MEM with the data address taken from alu_out.
  task automatic test_mem(input string name, input logic [15:0] word, input logic is_lw,
                          input logic [15:0] addr);
    vec_t got;
    vec_t exp;
    mem[m_pc] = word;
    alu_out = addr;
    sb.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 0, m_pc, m_pc, m_ir));
    sb.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 0, m_pc, m_pc, word));
    sb.push_back(mk(0, 0, 2'b00, 0, 2'b00, 1, 0, m_pc, m_pc, word));
    if (is_lw) sb.push_back(mk(1, 0, 2'b00, 0, 2'b00, 1, 0, m_pc, addr, word));
    else       sb.push_back(mk(0, 1, 2'b00, 1, 2'b00, 1, 0, m_pc, addr, word));
    m_ir = word;
    m_pc = m_pc + 16'd1;
    for (int i = 0; sb.size() > 0; i++) begin
      exp = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s cyc%0d got=%h exp=%h", name, i, got, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jalr(input logic [15:0] target);
    vec_t got;
    vec_t exp;
    mem[m_pc] = 16'hED00;
    reg_out1 = target;
    sb.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 0, m_pc, m_pc, m_ir));
    sb.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 0, m_pc, m_pc, 16'hED00));
    sb.push_back(mk(1, 0, 2'b10, 0, 2'b00, 0, 0, m_pc, m_pc, 16'hED00));
    m_ir = 16'hED00;
    m_pc = target;
    for (int i = 0; sb.size() > 0; i++) begin
      exp = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL jalr_to_%h cyc%0d got=%h exp=%h", target, i, got, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_beq(input logic [15:0] word, input logic eq, input logic [15:0] new_pc);
    vec_t got;
    vec_t exp;
    mem[m_pc] = word;
    alu_eq = eq;
    sb.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 0, m_pc, m_pc, m_ir));
    sb.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 0, m_pc, m_pc, word));
    sb.push_back(mk(0, 0, 2'b00, 1, 2'b00, 0, 0, m_pc, m_pc, word));
    // Next instruction's FETCH shows the branch result.
    sb.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 0, new_pc, new_pc, word));
    m_ir = word;
    m_pc = new_pc;
    for (int i = 0; sb.size() > 0; i++) begin
      exp = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL beq_%h_eq%0d cyc%0d got=%h exp=%h", word, eq, i, got, exp);
      end
      if (sb.size() > 0) @(negedge clk);
    end
    alu_eq = 1'b0;
  endtask

  task automatic test_halt();
    vec_t got;
    vec_t exp;
    mem[m_pc] = 16'hE001;
    sb.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 0, m_pc, m_pc, m_ir));
    sb.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 0, m_pc, m_pc, 16'hE001));
    for (int k = 0; k < 12; k++) begin
      sb.push_back(mk(0, 0, 2'b00, 0, 2'b00, 0, 1, m_pc, m_pc, 16'hE001));
    end
    for (int i = 0; sb.size() > 0; i++) begin
      exp = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL halt cyc%0d got=%h exp=%h", i, got, exp);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    got = obs();
    checks++;
    if (got !== mk(0, 0, 2'b00, 0, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0)) begin
      errors++;
      $display("FAIL halt_reset got=%h exp=%h", got, mk(0, 0, 2'b00, 0, 2'b00, 0, 0, 16'h0,
               16'h0, 16'h0));
    end
    rst_n = 1'b1;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    alu_out  = 16'h0000;
    alu_eq   = 1'b0;
    reg_out1 = 16'h0000;
    m_pc     = 16'h0000;
    m_ir     = 16'h0000;

    test_reset();
    test_reset_mid();
    test_wb("add", 16'h0503, 2'b00, 1'b0);
    test_mem("lw", 16'hA505, 1'b1, 16'h0107);
    test_mem("sw", 16'h8505, 1'b0, 16'h0107);
    test_wb("nand", 16'h4503, 2'b01, 1'b0);
    test_wb("lui", 16'h6ABC, 2'b10, 1'b0);
    test_wb("addi", 16'h257F, 2'b00, 1'b1);
    test_jalr(16'h0020);
    test_jalr(16'h1234);
    test_jalr(16'h0010);
    test_beq(16'hC4FE, 1'b1, 16'h000F);
    test_jalr(16'h0010);
    test_beq(16'hC4FE, 1'b0, 16'h0011);
    test_jalr(16'hFFFF);
    test_beq(16'hC401, 1'b1, 16'h0001);
    test_jalr(16'h0040);
    test_halt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle controller for the 16-bit core. Holds the program counter and instruction register, fetches from unified memory, and sequences each instruction through a fixed state machine. It sits directly upstream of the register file and drives that block's `instruction`, `pc`, `MUX_tgt`, `MUX_rf` and `WE_rf` inputs. It also drives the ALU controls and the memory address and write strobe.

## Interface
- No parameters. Data width is fixed at 16 and the register index width at 3.
- `clk` input 1: single clock; all state updates on posedge.
- `rst_n` input 1: synchronous, active-low reset.
- `mem_rdata` input 16: memory read data, valid combinationally for the current `mem_addr`.
- `alu_out` input 16: ALU result, stable while IR and controls are stable.
- `alu_eq` input 1: high when `reg_out1 == reg_out2`.
- `reg_out1` input 16: register file rB read port, used as the JALR target.
- `instruction` output 16: instruction register (IR).
- `pc` output 16: address of the instruction currently executing.
- `mem_addr` output 16: `pc` in FETCH, `alu_out` in MEM, `pc` otherwise.
- `mem_we` output 1: memory write strobe.
- `MUX_tgt` output 2: 00 mem_out, 01 alu_out, 10 pc+1.
- `MUX_rf` output 1: 0 selects rC, 1 selects rA on the second read port.
- `WE_rf` output 1: register file write enable.
- `alu_op` output 2: 00 ADD, 01 NAND, 10 LUI (result is `{imm10, 6'b0}`), 11 reserved (never driven).
- `alu_src_imm` output 1: 1 selects the sign-extended `IR[6:0]` as ALU operand B.
- `halted` output 1: core halted.

## Operation
- Opcode is `IR[15:13]`: ADD 000, ADDI 001, NAND 010, LUI 011, SW 100, LW 101, BEQ 110, JALR 111.
- HALT is JALR with `IR[6:0] != 0`.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- All outputs are Moore outputs: decoded from the state and IR. Strobes default to 0 and `MUX_tgt` defaults to 00.
- **FETCH**: `mem_addr = pc`; IR <= `mem_rdata`. Next state is DECODE.
- **DECODE**: no strobes. Next state is HALT if the IR encodes HALT, otherwise EXEC.
- **EXEC** drives `alu_op` and `alu_src_imm` per opcode. These hold unchanged through MEM and WB.
  - ADD, NAND: `alu_src_imm` = 0. Next state WB.
  - ADDI, LW, SW: `alu_src_imm` = 1, `alu_op` = 00. ADDI goes to WB; LW and SW go to MEM.
  - LUI: `alu_op` = 10. Next state WB.
  - BEQ: `MUX_rf` = 1. Sample `alu_eq`:
    - If set: `pc` <= `pc` + 1 + sext(`IR[6:0]`).
    - Otherwise: `pc` <= `pc` + 1.
    - Next state FETCH.
  - JALR: `WE_rf` = 1, `MUX_tgt` = 10, `pc` <= `reg_out1`. Next state FETCH.
- **MEM**: `mem_addr = alu_out`.
  - LW: `WE_rf` = 1, `MUX_tgt` = 00.
  - SW: `MUX_rf` = 1, `mem_we` = 1.
  - `pc` <= `pc` + 1. Next state FETCH.
- **WB**: `WE_rf` = 1, `MUX_tgt` = 01, `MUX_rf` = 0. `pc` <= `pc` + 1. Next state FETCH.
- **HALT**: `halted` = 1. No strobes; `pc` and IR are frozen. Only `rst_n` exits this state.
- PC arithmetic is modulo 2^16: 0xFFFF + 1 = 0x0000. Branch targets wrap the same way.

## Timing
- Reset at posedge with `rst_n` = 0 gives: state FETCH, `pc` 0x0000, IR 0x0000, `halted` 0.
  - All strobes are 0 and `MUX_tgt`, `alu_op`, `alu_src_imm`, `MUX_rf` are 0.
  - `mem_addr` is 0x0000, since it follows `pc` in FETCH.
- Reset takes priority over every transition. Reset asserted mid-instruction aborts it: no `WE_rf` or `mem_we` pulse occurs in that cycle, and `pc` is not advanced.
- Cycles per instruction:
  - ADD, ADDI, NAND, LUI: 4 (F, D, E, WB).
  - LW, SW: 4 (F, D, E, MEM).
  - BEQ, JALR: 3 (F, D, E).
  - HALT: 2 cycles to reach the HALT state.
- `WE_rf` and `mem_we` are high for exactly one cycle per instruction that writes.
- `pc` changes only on the final cycle of an instruction, so the register file sees the current instruction's `pc` for pc+1 writes.
- JALR with rA == rB: the jump target is the pre-write value of rB, because the read and the write happen in the same cycle.
- rA = 0 writes still pulse `WE_rf`; the register file suppresses them.

## Test plan
- **Reset mid-instruction**: run ADD 0x0503 and pull `rst_n` low during EXEC -> next cycle FETCH, `pc` 0x0000, IR 0x0000. No `WE_rf` pulse is seen.
- **ADD r1,r2,r3 (0x0503) at pc 0**: `WE_rf` = 1 only in cycle 4, with `MUX_tgt` = 01, `MUX_rf` = 0, `alu_op` = 00 -> `pc` = 0x0001 at the start of cycle 5.
- **LW r1,r2,5 (0xA505)** with `alu_out` 0x0107:
  - Cycle 4: `mem_addr` = 0x0107, `WE_rf` = 1, `MUX_tgt` = 00, `alu_src_imm` = 1.
  - `mem_we` stays 0 throughout.
  - SW (0x8505) under the same conditions gives `mem_we` = 1, `MUX_rf` = 1, `WE_rf` = 0.
- **BEQ r1,r1,-2 (0xC4FE) at pc 0x0010**:
  - `alu_eq` = 1 -> `pc` 0x000F after 3 cycles.
  - `alu_eq` = 0 -> `pc` 0x0011.
  - At pc 0xFFFF with offset +1 -> `pc` 0x0001.
- **JALR r3,r2 (0xED00) at pc 0x0020** with `reg_out1` 0x1234 -> cycle 3 `WE_rf` = 1, `MUX_tgt` = 10, then `pc` = 0x1234.
- **HALT (0xE001)**:
  - `halted` rises after DECODE and stays high for at least 10 cycles, with no strobes and `pc` frozen.
  - `rst_n` low then clears the core to FETCH with `pc` 0x0000.
